raizing_cen_bank: RTL and testbench



---
 rtl/raizing_cen_bank.sv | 112 +++++++++++
 tb/tb_raizing_cen_bank.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/raizing_cen_bank.sv
// Bank of independent fractional clock-enable generators (CEN / half-phase CENB) with
// runtime-reloadable NUM/DEN ratios applied only at CEN boundaries, plus per-channel pause.
module raizing_cen_bank #(
    parameter int unsigned NCH = 4,
    parameter int unsigned W   = 10
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [NCH*W-1:0] NUM,
    input  logic [NCH*W-1:0] DEN,
    input  logic [NCH-1:0]   LOAD,
    input  logic             PAUSE,
    input  logic [NCH-1:0]   PAUSE_MASK,
    output logic [NCH-1:0]   CEN,
    output logic [NCH-1:0]   CENB,
    output logic [NCH-1:0]   BUSY,
    output logic [NCH-1:0]   ERR
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        localparam int unsigned Lo = i * W;

        logic [W:0]   acc_q, acc_d;
        logic [W-1:0] num_a_q, num_a_d, den_a_q, den_a_d;
        logic [W-1:0] num_p_q, num_p_d, den_p_q, den_p_d;
        logic         busy_q, busy_d;
        logic         cen_q, cen_d, cenb_q, cenb_d, err_q, err_d;

        logic [W-1:0] num_in, den_in;
        logic [W:0]   sum, den_ext, half_ext;
        logic         legal, idle, paused, running, fire_c, fire_b;

        always_comb begin
            num_in   = NUM[Lo +: W];
            den_in   = DEN[Lo +: W];
            legal    = (num_in != '0) && ({num_in, 1'b0} <= {1'b0, den_in});
            idle     = (num_a_q == '0);
            paused   = PAUSE & PAUSE_MASK[i];
            running  = !idle && !paused;
            den_ext  = {1'b0, den_a_q};
            half_ext = {2'b00, den_a_q[W-1:1]};
            // acc < den_a and num_a <= den_a/2, so W+1 bits cannot overflow
            sum      = acc_q + {1'b0, num_a_q};
            fire_c   = running && (sum >= den_ext);
            fire_b   = running && (acc_q < half_ext) && (sum >= half_ext);

            acc_d   = acc_q;
            num_a_d = num_a_q;
            den_a_d = den_a_q;
            num_p_d = num_p_q;
            den_p_d = den_p_q;
            busy_d  = busy_q;
            cen_d   = fire_c;
            cenb_d  = fire_b;
            err_d   = LOAD[i] && !legal;

            if (running) begin
                acc_d = fire_c ? (sum - den_ext) : sum;
            end

            if (LOAD[i] && legal) begin
                if (idle) begin
                    // nothing to glitch on an idle channel: go live at once
                    num_a_d = num_in;
                    den_a_d = den_in;
                    acc_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    // a same-cycle boundary is skipped so the newest ratio wins
                    num_p_d = num_in;
                    den_p_d = den_in;
                    busy_d  = 1'b1;
                end
            end else if (busy_q && (idle || fire_c)) begin
                num_a_d = num_p_q;
                den_a_d = den_p_q;
                acc_d   = '0;
                busy_d  = 1'b0;
            end
        end

        always_ff @(posedge CLK) begin
            if (RESET) begin
                acc_q   <= '0;
                num_a_q <= '0;
                den_a_q <= W'(1);
                num_p_q <= '0;
                den_p_q <= W'(1);
                busy_q  <= 1'b0;
                cen_q   <= 1'b0;
                cenb_q  <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                acc_q   <= acc_d;
                num_a_q <= num_a_d;
                den_a_q <= den_a_d;
                num_p_q <= num_p_d;
                den_p_q <= den_p_d;
                busy_q  <= busy_d;
                cen_q   <= cen_d;
                cenb_q  <= cenb_d;
                err_q   <= err_d;
            end
        end

        assign CEN[i]  = cen_q;
        assign CENB[i] = cenb_q;
        assign BUSY[i] = busy_q;
        assign ERR[i]  = err_q;
    end

endmodule

// File: tb/tb_raizing_cen_bank.sv
// Directed self-checking bench for raizing_cen_bank: startup phase, long-window rate,
// glitch-free retune, pause phase preservation, illegal-ratio rejection and mid-run reset.
module tb_raizing_cen_bank;

    localparam int unsigned NCH = 4;
    localparam int unsigned W   = 10;

    logic             clk;
    logic             rst;
    logic [NCH*W-1:0] num;
    logic [NCH*W-1:0] den;
    logic [NCH-1:0]   load;
    logic             pause;
    logic [NCH-1:0]   pmask;
    logic [NCH-1:0]   cen;
    logic [NCH-1:0]   cenb;
    logic [NCH-1:0]   busy;
    logic [NCH-1:0]   err;

    int n_tests = 0;
    int n_fail  = 0;

    raizing_cen_bank #(
        .NCH(NCH),
        .W  (W)
    ) u_dut (
        .CLK       (clk),
        .RESET     (rst),
        .NUM       (num),
        .DEN       (den),
        .LOAD      (load),
        .PAUSE     (pause),
        .PAUSE_MASK(pmask),
        .CEN       (cen),
        .CENB      (cenb),
        .BUSY      (busy),
        .ERR       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ratio(input int ch, input int n, input int d);
        num[ch*W +: W] = W'(n);
        den[ch*W +: W] = W'(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_c [2];
        int cnt_b [2];
        int coinc;
        int last;
        int gmin;
        int gmax;
        int guard;
        logic c0, b0, c2, b2;

        rst   = 1'b1;
        num   = '0;
        den   = '0;
        load  = '0;
        pause = 1'b0;
        pmask = '0;
        tick();
        tick();
        check("reset_outputs", 32'({cen, cenb, busy, err}), 32'h0);
        rst = 1'b0;
        tick();
        check("idle_after_reset", 32'({cen, cenb, busy, err}), 32'h0);

        // ch0 1/4 from idle: CENB at t+3, CEN at t+5, then every 4
        set_ratio(0, 1, 4);
        load = 4'b0001;
        tick();
        load = '0;
        check("t1_busy_idle_load", 32'(busy), 32'h0);
        for (int k = 1; k <= 12; k++) begin
            check("t1_cen",  32'(cen),  32'((k % 4 == 1 && k >= 5) ? 1 : 0));
            check("t1_cenb", 32'(cenb), 32'((k % 4 == 3) ? 1 : 0));
            tick();
        end

        // ch1 9/128: 9 of each per 128 cycles, gaps 14/15, never coincident
        set_ratio(1, 9, 128);
        load = 4'b0010;
        tick();
        load = '0;
        tick();
        cnt_c[0] = 0; cnt_c[1] = 0; cnt_b[0] = 0; cnt_b[1] = 0;
        coinc = 0; last = -1; gmin = 1000; gmax = 0;
        for (int j = 0; j < 256; j++) begin
            if (cen[1]) begin
                cnt_c[j / 128]++;
                if (last >= 0) begin
                    if (j - last < gmin) gmin = j - last;
                    if (j - last > gmax) gmax = j - last;
                end
                last = j;
            end
            if (cenb[1]) cnt_b[j / 128]++;
            if (cen[1] && cenb[1]) coinc++;
            if (cen[0] && cenb[0]) coinc++;
            tick();
        end
        check("t2_cen_win0",  32'(cnt_c[0]), 32'd9);
        check("t2_cenb_win0", 32'(cnt_b[0]), 32'd9);
        check("t2_cen_win1",  32'(cnt_c[1]), 32'd9);
        check("t2_cenb_win1", 32'(cnt_b[1]), 32'd9);
        check("t2_coincident", 32'(coinc), 32'd0);
        check("t2_gap_min", 32'(gmin), 32'd14);
        check("t2_gap_max", 32'(gmax), 32'd15);

        // retune ch0 1/4 -> 1/2, LOAD two cycles after a CEN
        guard = 0;
        while (!cen[0] && guard < 8) begin
            tick();
            guard++;
        end
        check("t3_find_cen", 32'(cen[0]), 32'h1);
        tick();
        tick();
        check("t3_cenb_old", 32'(cenb[0]), 32'h1);
        set_ratio(0, 1, 2);
        load = 4'b0001;
        tick();
        load = '0;
        check("t3_busy_pending", 32'(busy[0]), 32'h1);
        check("t3_no_early_cen", 32'(cen[0]), 32'h0);
        tick();
        check("t3_boundary_cen", 32'(cen[0]), 32'h1);
        check("t3_busy_cleared", 32'(busy[0]), 32'h0);
        for (int k = 5; k <= 10; k++) begin
            tick();
            check("t3_new_cen",  32'(cen[0]),  32'((k % 2 == 0) ? 1 : 0));
            check("t3_new_cenb", 32'(cenb[0]), 32'((k % 2 == 1) ? 1 : 0));
        end

        // pause ch0 (1/4) for 10 cycles, ch2 (1/3) free-running
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_ratio(0, 1, 4);
        set_ratio(2, 1, 3);
        load = 4'b0101;
        tick();
        load  = '0;
        pmask = 4'b0001;
        for (int k = 1; k <= 30; k++) begin
            int d;
            int n;
            pause = (k >= 8 && k <= 17);
            d = k - 1;
            n = (d >= 18) ? d - 10 : d;
            c0 = !(d >= 8 && d <= 17) && n >= 1 && (n % 4 == 0);
            b0 = !(d >= 8 && d <= 17) && n >= 1 && (n % 4 == 2);
            c2 = d >= 1 && (d % 3 == 0);
            b2 = d >= 1 && (d % 3 == 1);
            check("t4_cen",  32'(cen),  32'({1'b0, c2, 1'b0, c0}));
            check("t4_cenb", 32'(cenb), 32'({1'b0, b2, 1'b0, b0}));
            tick();
        end
        pause = 1'b0;

        // ch3 illegal ratios rejected, then 2/4 boundary accepted
        set_ratio(3, 3, 4);
        load = 4'b1000;
        tick();
        load = '0;
        check("t5_err_3_4", 32'(err), 32'h8);
        check("t5_busy_3_4", 32'(busy), 32'h0);
        tick();
        check("t5_err_pulse_end", 32'(err), 32'h0);
        for (int k = 0; k < 6; k++) begin
            check("t5_ch3_silent", 32'({cen[3], cenb[3]}), 32'h0);
            tick();
        end
        set_ratio(3, 0, 4);
        load = 4'b1000;
        tick();
        load = '0;
        check("t5_err_num0", 32'(err), 32'h8);
        tick();
        check("t5_err_num0_end", 32'(err), 32'h0);
        check("t5_ch3_still_idle", 32'({cen[3], cenb[3]}), 32'h0);
        set_ratio(3, 2, 4);
        load = 4'b1000;
        tick();
        load = '0;
        check("t5_err_2_4", 32'(err), 32'h0);
        tick();
        check("t5_cenb_2_4", 32'(cenb[3]), 32'h1);
        tick();
        check("t5_cen_2_4", 32'(cen[3]), 32'h1);

        // reset mid-stream with a retune pending on ch0
        set_ratio(0, 1, 2);
        load = 4'b0001;
        tick();
        load = '0;
        check("t6_busy_before_reset", 32'(busy[0]), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_outputs_after_reset", 32'({cen, cenb, busy, err}), 32'h0);
        for (int k = 0; k < 12; k++) begin
            tick();
            check("t6_silent", 32'({cen, cenb, busy, err}), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
